// File: rtl/dmem_pkg.sv
// Shared types and widths for the latency-injecting data-memory responder
// and the address decoder that the future cache fill path will also use.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } dmem_state_t;

   localparam int DATA_W = 32;
   localparam int CNT_W  = 8;

endpackage

// File: rtl/dmem_addr_decode.sv
// Byte address to word index translation with range and alignment checking.
module dmem_addr_decode #(
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0000,
   parameter int unsigned WORD_DEPTH = 36,
   parameter int          IDX_W      = 6
) (
   input  logic [31:0]      addr,
   output logic [IDX_W-1:0] index,
   output logic             bad
);

   logic [31:0] offset;
   logic [31:0] word_off;

   assign offset   = addr - BASE_ADDR;
   assign word_off = offset >> 2;
   assign index    = word_off[IDX_W-1:0];

   // The offset wraps when addr is below the base, so that case is tested on its own.
   assign bad = (addr < BASE_ADDR) ||
                (word_off >= 32'(WORD_DEPTH)) ||
                (addr[1:0] != 2'b00);

endmodule

// File: rtl/dmem_latency_slave.sv
// Data-memory responder that answers each request after LATENCY wait cycles,
// holding the core with a combinational stall until the DONE cycle.
module dmem_latency_slave
   import dmem_pkg::*;
#(
   parameter int unsigned WORD_DEPTH = 36,
   parameter int unsigned LATENCY    = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cen,
   input  logic              wen,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic              stall,
   output logic [DATA_W-1:0] rdata,
   output logic              err
);

   localparam int IDX_W = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1;

   dmem_state_t       state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg, cnt_next;
   logic [IDX_W-1:0]  index_reg;
   logic              bad_reg;
   logic              wen_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic              err_reg;
   logic [IDX_W-1:0]  index;
   logic              bad;
   logic              access;

   // Not reset: preloaded and inspected by the environment through hierarchy.
   logic [DATA_W-1:0] mem [WORD_DEPTH];

   dmem_addr_decode #(
      .BASE_ADDR  (BASE_ADDR),
      .WORD_DEPTH (WORD_DEPTH),
      .IDX_W      (IDX_W)
   ) u_decode (
      .addr  (addr),
      .index (index),
      .bad   (bad)
   );

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      access     = 1'b0;
      stall      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cen) begin
               stall      = 1'b1;
               cnt_next   = CNT_W'(LATENCY - 1);
               state_next = BUSY;
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               access     = 1'b1;
               state_next = DONE;
            end
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
      // A request held across reset must not stall the core while reset is active.
      if (!rst_n) stall = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         index_reg <= '0;
         bad_reg   <= 1'b0;
         wen_reg   <= 1'b0;
         wdata_reg <= '0;
         rdata_reg <= '0;
         err_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == IDLE && cen) begin
            index_reg <= index;
            bad_reg   <= bad;
            wen_reg   <= wen;
            wdata_reg <= wdata;
         end
         if (access) begin
            err_reg <= bad_reg;
            if (!bad_reg && !wen_reg) rdata_reg <= mem[index_reg];
            else                      rdata_reg <= '0;
         end else if (state_reg == DONE) begin
            err_reg <= 1'b0;
         end
      end
   end

   // access is derived from the reset state register, so a reset mid-request drops the write.
   always_ff @(posedge clk) begin
      if (access && wen_reg && !bad_reg) mem[index_reg] <= wdata_reg;
   end

   assign rdata = rdata_reg;
   assign err   = err_reg;

endmodule

// File: tb/tb_dmem_latency_slave.sv
// Directed bench for dmem_latency_slave at LATENCY 4, 1 and 255.
module tb_dmem_latency_slave;
   import dmem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        cen;
   logic        wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [1:0]  sel;

   logic        cen_a, cen_b, cen_c;
   logic        stall_a, stall_b, stall_c, stall_m;
   logic [31:0] rdata_a, rdata_b, rdata_c, rdata_m;
   logic        err_a, err_b, err_c, err_m;

   int checks;
   int errors;
   int sc;
   logic [31:0] rd;
   logic        e;
   longint      t0;

   assign cen_a = cen && (sel == 2'd0);
   assign cen_b = cen && (sel == 2'd1);
   assign cen_c = cen && (sel == 2'd2);

   always_comb begin
      stall_m = stall_a;
      rdata_m = rdata_a;
      err_m   = err_a;
      if (sel == 2'd1) begin
         stall_m = stall_b;
         rdata_m = rdata_b;
         err_m   = err_b;
      end else if (sel == 2'd2) begin
         stall_m = stall_c;
         rdata_m = rdata_c;
         err_m   = err_c;
      end
   end

   dmem_latency_slave #(.WORD_DEPTH(36), .LATENCY(4), .BASE_ADDR(32'h1001_0000)) dut_a (
      .clk(clk), .rst_n(rst_n), .cen(cen_a), .wen(wen), .addr(addr), .wdata(wdata),
      .stall(stall_a), .rdata(rdata_a), .err(err_a));

   dmem_latency_slave #(.WORD_DEPTH(36), .LATENCY(1), .BASE_ADDR(32'h1001_0000)) dut_b (
      .clk(clk), .rst_n(rst_n), .cen(cen_b), .wen(wen), .addr(addr), .wdata(wdata),
      .stall(stall_b), .rdata(rdata_b), .err(err_b));

   dmem_latency_slave #(.WORD_DEPTH(36), .LATENCY(255), .BASE_ADDR(32'h1001_0000)) dut_c (
      .clk(clk), .rst_n(rst_n), .cen(cen_c), .wen(wen), .addr(addr), .wdata(wdata),
      .stall(stall_c), .rdata(rdata_c), .err(err_c));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Entered 1ns after a rising edge; returns 1ns after the edge that ends DONE.
   task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                         input bit hold, output int stall_cyc,
                         output logic [31:0] rdv, output logic ev);
      bit done;
      done      = 1'b0;
      stall_cyc = 0;
      rdv       = '0;
      ev        = 1'b0;
      cen   = 1'b1;
      wen   = w;
      addr  = a;
      wdata = d;
      for (int i = 0; i < 300 && !done; i++) begin
         #4;
         if (stall_m) stall_cyc++;
         else begin
            done = 1'b1;
            rdv  = rdata_m;
            ev   = err_m;
         end
         @(posedge clk);
         #1;
      end
      if (!hold) cen = 1'b0;
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL req_timeout addr=%h stall never dropped within 300 cycles", a);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cen   = 1'b1;
      wen   = 1'b0;
      addr  = 32'h1001_0000;
      wdata = '0;
      sel   = 2'd0;
      #2;
      checks++;
      if (stall_a !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_a); end
      checks++;
      if (rdata_a !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", rdata_a); end
      checks++;
      if (err_a !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err_a); end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (dut_a.state_reg !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", dut_a.state_reg); end
      cen   = 1'b0;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (dut_a.state_reg !== IDLE || stall_a !== 1'b0) begin
         errors++;
         $display("FAIL reset_release state=%0d stall=%b exp IDLE/0", dut_a.state_reg, stall_a);
      end
   endtask

   task automatic test_store_load();
      sel = 2'd0;
      do_req(32'h1001_0008, 1'b1, 32'hDEAD_BEEF, 1'b0, sc, rd, e);
      $display("store a=10010008 d=deadbeef stall=%0d err=%b", sc, e);
      checks++;
      if (sc !== 5) begin errors++; $display("FAIL store_stall got=%0d exp=5", sc); end
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL store_err got=%b exp=0", e); end
      checks++;
      if (dut_a.mem[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_mem2 got=%h exp=deadbeef", dut_a.mem[2]); end
      do_req(32'h1001_0008, 1'b0, 32'h0, 1'b0, sc, rd, e);
      $display("load  a=10010008 rdata=%h stall=%0d err=%b", rd, sc, e);
      checks++;
      if (rd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
      checks++;
      if (sc !== 5) begin errors++; $display("FAIL load_stall got=%0d exp=5", sc); end
   endtask

   task automatic test_out_of_range();
      sel = 2'd0;
      do_req(32'h1001_0090, 1'b0, 32'h0, 1'b0, sc, rd, e);
      $display("load  a=10010090 rdata=%h err=%b", rd, e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL oob_load_err got=%b exp=1", e); end
      checks++;
      if (rd !== 32'h0) begin errors++; $display("FAIL oob_load_rdata got=%h exp=0", rd); end
      checks++;
      if (err_a !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err_a); end
      do_req(32'h1001_000A, 1'b1, 32'h1234_5678, 1'b0, sc, rd, e);
      $display("store a=1001000a d=12345678 err=%b", e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL misalign_err got=%b exp=1", e); end
      checks++;
      if (dut_a.mem[2] !== 32'hDEAD_BEEF) begin errors++; $display("FAIL misalign_mem2 got=%h exp=deadbeef", dut_a.mem[2]); end
      do_req(32'h1000_FFFC, 1'b0, 32'h0, 1'b0, sc, rd, e);
      $display("load  a=1000fffc err=%b", e);
      checks++;
      if (e !== 1'b1) begin errors++; $display("FAIL below_base_err got=%b exp=1", e); end
      do_req(32'h1001_008C, 1'b1, 32'h1111_1111, 1'b0, sc, rd, e);
      $display("store a=1001008c d=11111111 err=%b", e);
      checks++;
      if (e !== 1'b0) begin errors++; $display("FAIL last_word_err got=%b exp=0", e); end
      checks++;
      if (dut_a.mem[35] !== 32'h1111_1111) begin errors++; $display("FAIL last_word_mem got=%h exp=11111111", dut_a.mem[35]); end
   endtask

   task automatic test_back_to_back();
      sel = 2'd0;
      t0  = $time;
      do_req(32'h1001_0008, 1'b0, 32'h0, 1'b1, sc, rd, e);
      $display("b2b load a=10010008 rdata=%h stall=%0d", rd, sc);
      checks++;
      if (sc !== 5 || rd !== 32'hDEAD_BEEF) begin
         errors++;
         $display("FAIL b2b_first stall=%0d rdata=%h exp 5/deadbeef", sc, rd);
      end
      do_req(32'h1001_008C, 1'b0, 32'h0, 1'b0, sc, rd, e);
      $display("b2b load a=1001008c rdata=%h stall=%0d", rd, sc);
      checks++;
      if (sc !== 5 || rd !== 32'h1111_1111) begin
         errors++;
         $display("FAIL b2b_second stall=%0d rdata=%h exp 5/11111111", sc, rd);
      end
      checks++;
      if (($time - t0) != 120) begin errors++; $display("FAIL b2b_total got=%0d exp=120", $time - t0); end
      #4;
      checks++;
      if (dut_a.state_reg !== IDLE || stall_a !== 1'b0) begin
         errors++;
         $display("FAIL b2b_no_double state=%0d stall=%b exp IDLE/0", dut_a.state_reg, stall_a);
      end
   endtask

   task automatic test_reset_mid_busy();
      sel = 2'd0;
      @(posedge clk);
      #1;
      do_req(32'h1001_0000, 1'b1, 32'hA5A5_A5A5, 1'b0, sc, rd, e);
      checks++;
      if (dut_a.mem[0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL preload_mem0 got=%h exp=a5a5a5a5", dut_a.mem[0]); end
      cen   = 1'b1;
      wen   = 1'b1;
      addr  = 32'h1001_0000;
      wdata = 32'h5A5A_5A5A;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      cen   = 1'b0;
      #1;
      $display("reset mid-busy state=%0d stall=%b", dut_a.state_reg, stall_a);
      checks++;
      if (dut_a.state_reg !== IDLE || stall_a !== 1'b0) begin
         errors++;
         $display("FAIL midbusy_state state=%0d stall=%b exp IDLE/0", dut_a.state_reg, stall_a);
      end
      #2;
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      checks++;
      if (dut_a.mem[0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL midbusy_mem0 got=%h exp=a5a5a5a5", dut_a.mem[0]); end
      do_req(32'h1001_0000, 1'b0, 32'h0, 1'b0, sc, rd, e);
      $display("load  a=10010000 rdata=%h stall=%0d", rd, sc);
      checks++;
      if (rd !== 32'hA5A5_A5A5 || sc !== 5) begin
         errors++;
         $display("FAIL midbusy_reload rdata=%h stall=%0d exp a5a5a5a5/5", rd, sc);
      end
   endtask

   task automatic test_latency_sweep();
      sel = 2'd1;
      do_req(32'h1001_0010, 1'b1, 32'hCAFE_F00D, 1'b0, sc, rd, e);
      $display("lat1   store a=10010010 stall=%0d", sc);
      checks++;
      if (sc !== 2) begin errors++; $display("FAIL lat1_store_stall got=%0d exp=2", sc); end
      checks++;
      if (dut_b.mem[4] !== 32'hCAFE_F00D) begin errors++; $display("FAIL lat1_mem4 got=%h exp=cafef00d", dut_b.mem[4]); end
      do_req(32'h1001_0010, 1'b0, 32'h0, 1'b0, sc, rd, e);
      $display("lat1   load  a=10010010 rdata=%h stall=%0d", rd, sc);
      checks++;
      if (sc !== 2 || rd !== 32'hCAFE_F00D) begin
         errors++;
         $display("FAIL lat1_load stall=%0d rdata=%h exp 2/cafef00d", sc, rd);
      end
      sel = 2'd2;
      do_req(32'h1001_0004, 1'b1, 32'h0BAD_C0DE, 1'b0, sc, rd, e);
      $display("lat255 store a=10010004 stall=%0d", sc);
      checks++;
      if (sc !== 256) begin errors++; $display("FAIL lat255_store_stall got=%0d exp=256", sc); end
      do_req(32'h1001_0004, 1'b0, 32'h0, 1'b0, sc, rd, e);
      $display("lat255 load  a=10010004 rdata=%h stall=%0d", rd, sc);
      checks++;
      if (sc !== 256 || rd !== 32'h0BAD_C0DE) begin
         errors++;
         $display("FAIL lat255_load stall=%0d rdata=%h exp 256/0badc0de", sc, rd);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_store_load();
      test_out_of_range();
      test_back_to_back();
      test_reset_mid_busy();
      test_latency_sweep();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dmem_latency_slave.md
# dmem_latency_slave

Data-memory responder for the single-cycle CPU core's data port. It answers CPU load/store requests after a configurable number of wait cycles and holds the core with a `stall` signal. Bring-up uses it to prove the core tolerates slow memory before a cache exists. It sits between the core's data-memory port and the simulation environment, and exposes its word array for hierarchical preload and answer checking.

## Interface
- `WORD_DEPTH`, default 36: number of 32-bit words in the array.
- `LATENCY`, default 4: wait cycles spent in BUSY; legal range 1..255.
- `BASE_ADDR`, default 32'h10010000: byte address of word 0.
- `clk`  in  1: the single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cen`  in  1: request valid, held by the core until it sees `stall` low.
- `wen`  in  1: 1 = store, 0 = load; sampled with `cen`.
- `addr`  in  32: byte address.
- `wdata`  in  32: store data.
- `stall`  out  1: core must hold its PC and request while high.
- `rdata`  out  32: load result; valid in DONE.
- `err`  out  1: request was out of range or misaligned; valid in DONE.

## Operation
- States:
  - IDLE
  - BUSY: counter `cnt`, 8 bits.
  - DONE
- Address decode: index = (addr − BASE_ADDR) >> 2.
  - `bad` = addr < BASE_ADDR, or index ≥ WORD_DEPTH, or addr[1:0] ≠ 0.
- IDLE:
  - If `cen`=1: latch addr, wen, wdata and bad; cnt ← LATENCY−1; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - Inputs are ignored; only the latched copies are used.
  - If cnt ≠ 0: cnt ← cnt−1.
  - If cnt = 0, perform the access and go to DONE:
    - Good store: mem[index] ← wdata; rdata ← 0.
    - Good load: rdata ← mem[index].
    - Bad request: no array write; rdata ← 0; err ← 1.
- DONE:
  - Unconditionally return to IDLE.
  - A `cen` seen in DONE belongs to the current, already-served request and is ignored.
- Leaving DONE clears `err` to 0. `rdata` holds its value until the next access completes.
- The array `mem` is not reset. The environment preloads and inspects it by hierarchical reference.

## Timing
- `stall` is combinational:
  - 1 when (IDLE and cen), or in BUSY.
  - 0 in DONE, and 0 in IDLE with cen = 0.
- Request accepted in cycle 0 (IDLE):
  - BUSY occupies cycles 1..LATENCY.
  - DONE is cycle LATENCY+1, with `stall` = 0 and rdata/err valid.
  - The core advances on the rising edge that ends DONE.
- Total stall per access: LATENCY+1 cycles. Back-to-back requests take LATENCY+2 cycles each.
- A store writes the array on the edge leaving BUSY. A load issued next is served after that edge and sees the new data.
- Reset values: state = IDLE, cnt = 0, rdata = 0, err = 0, stall = 0 (given cen = 0).
- Reset asserted mid-request:
  - Returns to IDLE immediately.
  - Discards the latched request; a pending store is never written.
  - The array is unchanged.
- LATENCY = 1: BUSY lasts one cycle.

## Structure
- Package `dmem_pkg`:
  - State enum `dmem_state_t` {IDLE, BUSY, DONE}.
  - Constants DATA_W = 32 and CNT_W = 8.
- Sub-module `dmem_addr_decode`:
  - Purely combinational, parameterised by BASE_ADDR and WORD_DEPTH.
  - Outputs `index` and `bad`. It is reused later by the cache fill path.
- Top level holds the FSM, the counter, the request latch and the array.

## Test plan
- Reset: hold rst_n = 0 with cen = 1 → stall = 0, rdata = 0, err = 0. After release, the first request starts in IDLE.
- Store/load, LATENCY = 4:
  - Store 32'hDEADBEEF at 32'h10010008 → stall high exactly 5 cycles; mem[2] = 32'hDEADBEEF.
  - Following load from the same address → rdata = 32'hDEADBEEF in DONE.
- Out of range:
  - Load 32'h10010090 (index 36) → err = 1 and rdata = 0 in DONE.
  - Store 32'h1001000A (misaligned) → err = 1; array unchanged.
- Back-to-back: two loads issued with cen held continuously → each takes 6 cycles; the DONE-cycle cen is not double-counted.
- Reset mid-BUSY: assert rst_n = 0 two cycles into a store to 32'h10010000 → FSM returns to IDLE; mem[0] keeps its preloaded value.
- Latency sweep: LATENCY = 1 and LATENCY = 255 → stall length = LATENCY+1 cycles; data correct at both extremes.
